// File: rtl/core_pkg.sv
// Shared decode definitions for the core front end.
//  - OPC_* : RV32 base opcodes (instr[6:0]) recognised by the decode stage
//  - instr_type_t : one-hot instruction-type flags plus an illegal marker
//  - decode_opcode() : pure combinational classifier from opcode to flags
package core_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic rtype;
    logic itype;
    logic load;
    logic store;
    logic branch;
    logic jalr;
    logic jal;
    logic lui;
    logic auipc;
    logic illegal;
  } instr_type_t;

  localparam int unsigned INSTR_TYPE_W = $bits(instr_type_t);

  // Exactly one field of the result is set. Compressed encodings
  // (opcode[1:0] != 2'b11) are rejected before the opcode table is consulted.
  function automatic instr_type_t decode_opcode(input logic [6:0] opcode);
    instr_type_t t;
    t = '0;
    if (opcode[1:0] != 2'b11) begin
      t.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_RTYPE:  t.rtype   = 1'b1;
        OPC_ITYPE:  t.itype   = 1'b1;
        OPC_LOAD:   t.load    = 1'b1;
        OPC_STORE:  t.store   = 1'b1;
        OPC_BRANCH: t.branch  = 1'b1;
        OPC_JALR:   t.jalr    = 1'b1;
        OPC_JAL:    t.jal     = 1'b1;
        OPC_LUI:    t.lui     = 1'b1;
        OPC_AUIPC:  t.auipc   = 1'b1;
        default:    t.illegal = 1'b1;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer with EMPTY/ONE/FULL occupancy control.
//  clk_i, rst_ni     : clock, asynchronous active-low reset
//  valid_i/ready_o   : upstream handshake; ready_o is decoded from the state register only
//  data_i            : incoming payload
//  flush_i           : drop all held entries and any same-cycle incoming entry
//  valid_o/ready_i   : downstream handshake
//  data_o            : main-register payload (the oldest held entry)
module skid_buf
  #(parameter int unsigned W = 8)
  (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    input  logic         flush_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
  );

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         main_ld, main_from_skid, skid_ld;
  logic         push, pop;

  // Both handshake outputs come straight from the state register, so there
  // is no combinational path from ready_i to ready_o.
  assign valid_o = (state_q != S_EMPTY);
  assign ready_o = (state_q != S_FULL);
  assign data_o  = main_q;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush_i) begin
      // Flush wins over everything; a same-cycle push is simply not stored.
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (push) begin
            main_ld = 1'b1;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            skid_ld = 1'b1;
            state_d = S_FULL;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // ready_o is low here, so push cannot occur.
          if (pop) begin
            main_from_skid = 1'b1;
            state_d        = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  // NOTE: the payload storage has no reset; its contents are never visible
  // while the occupancy state says the entry is invalid.
  always_ff @(posedge clk_i) begin
    if (main_ld)             main_q <= data_i;
    else if (main_from_skid) main_q <= skid_q;
    if (skid_ld)             skid_q <= data_i;
  end

endmodule

// File: rtl/instr_type_decode_stage.sv
// Decode-stage front end: classifies the incoming opcode into one-hot type
// flags and registers them with the instruction and PC through a 2-entry
// skid buffer (1-cycle latency, full throughput).
//  clk_i, rst_ni       : clock, asynchronous active-low reset
//  valid_i/ready_o     : fetch handshake (ready_o registered)
//  instr_i, pc_i       : incoming instruction word and its address
//  flush_i             : discard held and incoming entries
//  valid_o/ready_i     : downstream handshake
//  instr_o, pc_o       : registered instruction and PC (0 when valid_o=0)
//  rtype_o .. auipc_o  : one-hot type flags (0 when valid_o=0)
//  illegal_o           : unrecognised opcode
module instr_type_decode_stage
  import core_pkg::*;
  #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
  )
  (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            rtype_o,
    output logic            itype_o,
    output logic            load_o,
    output logic            store_o,
    output logic            branch_o,
    output logic            jalr_o,
    output logic            jal_o,
    output logic            lui_o,
    output logic            auipc_o,
    output logic            illegal_o
  );

  localparam int unsigned PAYLOAD_W = ILEN + XLEN + INSTR_TYPE_W;

  instr_type_t            type_in, type_held, type_out;
  logic [PAYLOAD_W-1:0]   payload_in, payload_out;
  logic [ILEN-1:0]        instr_held;
  logic [XLEN-1:0]        pc_held;

  // Decode ahead of the register so the flags travel with their instruction.
  assign type_in    = decode_opcode(instr_i[6:0]);
  assign payload_in = {instr_i, pc_i, type_in};

  skid_buf #(.W(PAYLOAD_W)) u_skid_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (payload_in),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (payload_out)
  );

  assign {instr_held, pc_held, type_held} = payload_out;

  // The held payload is unreset storage, so it is masked whenever no valid
  // entry is being presented.
  assign instr_o  = valid_o ? instr_held : '0;
  assign pc_o     = valid_o ? pc_held    : '0;
  assign type_out = valid_o ? type_held  : '0;

  assign rtype_o   = type_out.rtype;
  assign itype_o   = type_out.itype;
  assign load_o    = type_out.load;
  assign store_o   = type_out.store;
  assign branch_o  = type_out.branch;
  assign jalr_o    = type_out.jalr;
  assign jal_o     = type_out.jal;
  assign lui_o     = type_out.lui;
  assign auipc_o   = type_out.auipc;
  assign illegal_o = type_out.illegal;

endmodule

// File: tb/tb_instr_type_decode_stage.sv
// Directed bench for instr_type_decode_stage. Inputs change 1 ns after the
// rising edge; outputs are checked at the same point, away from the edge.
module tb_instr_type_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_i, flush_i;
  logic        ready_o, valid_o;
  logic [31:0] instr_i, pc_i, instr_o, pc_o;
  logic        rtype_o, itype_o, load_o, store_o, branch_o;
  logic        jalr_o, jal_o, lui_o, auipc_o, illegal_o;

  int checks   = 0;
  int failures = 0;

  // Flag vector order: {rtype,itype,load,store,branch,jalr,jal,lui,auipc,illegal}
  localparam logic [9:0] F_NONE   = 10'b00_0000_0000;
  localparam logic [9:0] F_RTYPE  = 10'b10_0000_0000;
  localparam logic [9:0] F_ITYPE  = 10'b01_0000_0000;
  localparam logic [9:0] F_LOAD   = 10'b00_1000_0000;
  localparam logic [9:0] F_STORE  = 10'b00_0100_0000;
  localparam logic [9:0] F_BRANCH = 10'b00_0010_0000;
  localparam logic [9:0] F_JALR   = 10'b00_0001_0000;
  localparam logic [9:0] F_JAL    = 10'b00_0000_1000;
  localparam logic [9:0] F_LUI    = 10'b00_0000_0100;
  localparam logic [9:0] F_AUIPC  = 10'b00_0000_0010;
  localparam logic [9:0] F_ILLEG  = 10'b00_0000_0001;

  logic [9:0] flags;
  assign flags = {rtype_o, itype_o, load_o, store_o, branch_o,
                  jalr_o, jal_o, lui_o, auipc_o, illegal_o};

  always #5 clk_i = ~clk_i;

  instr_type_decode_stage #(.XLEN(32), .ILEN(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .instr_i   (instr_i),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .rtype_o   (rtype_o),
    .itype_o   (itype_o),
    .load_o    (load_o),
    .store_o   (store_o),
    .branch_o  (branch_o),
    .jalr_o    (jalr_o),
    .jal_o     (jal_o),
    .lui_o     (lui_o),
    .auipc_o   (auipc_o),
    .illegal_o (illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full output check of one presented (or absent) entry.
  task automatic check_out(input string tag, input logic exp_valid, input logic exp_ready,
                           input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                           input logic [9:0] exp_flags);
    check({tag, ".valid"}, 64'(valid_o), 64'(exp_valid));
    check({tag, ".ready"}, 64'(ready_o), 64'(exp_ready));
    check({tag, ".instr"}, 64'(instr_o), 64'(exp_instr));
    check({tag, ".pc"},    64'(pc_o),    64'(exp_pc));
    check({tag, ".flags"}, 64'(flags),   64'(exp_flags));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    valid_i = v;
    instr_i = ins;
    pc_i    = pc;
  endtask

  logic [31:0] stream_ins [4];
  logic [9:0]  stream_flg [4];

  initial begin
    stream_ins = '{32'h0000_0013, 32'h0000_2083, 32'h0011_2023, 32'hFE00_0EE3};
    stream_flg = '{F_ITYPE, F_LOAD, F_STORE, F_BRANCH};

    rst_ni  = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #22;
    check_out("reset", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);
    rst_ni = 1'b1;
    tick();

    // 1. single add, one-cycle latency
    ready_i = 1'b1;
    drive(1'b1, 32'h00B5_0533, 32'h0);
    tick();
    check_out("t1_add", 1'b1, 1'b1, 32'h00B5_0533, 32'h0, F_RTYPE);

    // 2. back-to-back stream with no bubbles
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream_ins[i], 32'(4 * (i + 1)));
      tick();
      check_out($sformatf("t2_s%0d", i), 1'b1, 1'b1, stream_ins[i], 32'(4 * (i + 1)), stream_flg[i]);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_out("t2_drain", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);

    // 3. fill to FULL under back-pressure, then drain in order
    ready_i = 1'b0;
    drive(1'b1, 32'h0000_006F, 32'h100);
    tick();
    check_out("t3_one", 1'b1, 1'b1, 32'h0000_006F, 32'h100, F_JAL);
    drive(1'b1, 32'h0000_00B7, 32'h104);
    tick();
    check_out("t3_full", 1'b1, 1'b0, 32'h0000_006F, 32'h100, F_JAL);
    drive(1'b1, 32'h0000_0013, 32'h108);  // must be refused while FULL
    tick();
    check_out("t3_hold", 1'b1, 1'b0, 32'h0000_006F, 32'h100, F_JAL);
    drive(1'b0, 32'h0, 32'h0);
    ready_i = 1'b1;
    tick();
    check_out("t3_lui", 1'b1, 1'b1, 32'h0000_00B7, 32'h104, F_LUI);
    tick();
    check_out("t3_empty", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);

    // 4. flush while FULL with an auipc presented
    ready_i = 1'b0;
    drive(1'b1, 32'h0000_006F, 32'h200);
    tick();
    drive(1'b1, 32'h0000_00B7, 32'h204);
    tick();
    check_out("t4_full", 1'b1, 1'b0, 32'h0000_006F, 32'h200, F_JAL);
    drive(1'b1, 32'h0000_0017, 32'h208);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_out("t4_flush", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_quiet%0d", i), 64'(valid_o), 64'd0);
    end

    // 4b. flush in ONE discards a same-cycle accepted auipc
    ready_i = 1'b0;
    drive(1'b1, 32'h0000_0067, 32'h300);
    tick();
    check_out("t4b_jalr", 1'b1, 1'b1, 32'h0000_0067, 32'h300, F_JALR);
    drive(1'b1, 32'h0000_0017, 32'h304);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check_out("t4b_flush", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);
    tick();
    check("t4b_quiet", 64'(valid_o), 64'd0);

    // 5. illegal opcodes and a legal auipc
    ready_i = 1'b1;
    drive(1'b1, 32'h0000_007F, 32'h400);
    tick();
    check_out("t5_7f", 1'b1, 1'b1, 32'h0000_007F, 32'h400, F_ILLEG);
    drive(1'b1, 32'h0000_0032, 32'h404);
    tick();
    check_out("t5_32", 1'b1, 1'b1, 32'h0000_0032, 32'h404, F_ILLEG);
    drive(1'b1, 32'h0000_0017, 32'h408);
    tick();
    check_out("t5_auipc", 1'b1, 1'b1, 32'h0000_0017, 32'h408, F_AUIPC);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check_out("t5_empty", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);

    // 6. asynchronous reset while holding one entry
    ready_i = 1'b0;
    drive(1'b1, 32'h00B5_0533, 32'h500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check_out("t6_one", 1'b1, 1'b1, 32'h00B5_0533, 32'h500, F_RTYPE);
    #2;
    rst_ni = 1'b0;
    #1;  // still before the next rising edge
    check_out("t6_async", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);
    #3;
    rst_ni = 1'b1;
    tick();
    check_out("t6_release", 1'b0, 1'b1, 32'h0, 32'h0, F_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
